multicycle_ctrl: RTL
====================

# multicycle_ctrl

Moore-style control FSM that sequences the shared multicycle ARM datapath: one ALU, one unified instruction/data memory port and one register file are reused across FETCH, DECODE and EXECUTE/MEMORY/WRITEBACK cycles. The block consumes instruction fields already latched in the instruction register plus the condition-check result, and drives every mux select and write strobe of the datapath. It sits beside the combinational instruction decoder, which still supplies `alu_ctl`, `flag_w`, `imm_src`, `reg_src` and `no_write`.

## Interface
- (no parameters; all widths fixed by the datapath)
- `clk` in 1: rising-edge clock
- `reset_n` in 1: asynchronous active-low reset
- `op` in 2: instr[27:26]
- `funct` in 6: instr[25:20]; bit5 = I, bit0 = L/S
- `cond_ex` in 1: condition-check pass for the latched instruction
- `no_write` in 1: compare-class op; suppresses register writeback
- `mem_ready` in 1: memory completion (used only with `MEM_WAIT_EN`)
- `mem_req` out 1: memory access active this cycle
- `ir_write` out 1: latch instruction register
- `pc_write` out 1: unconditional PC update (PC+4)
- `adr_src` out 1: memory address 0 = PC, 1 = ALU result register
- `alu_src_a` out 2: 0 = Rn, 1 = PC, 2 = 0
- `alu_src_b` out 2: 0 = Rm, 1 = extended immediate, 2 = constant 4
- `result_src` out 2: 0 = ALU result register, 1 = read data, 2 = ALU output direct
- `alu_op` out 1: 1 = use decoded `alu_ctl`; 0 = force ADD
- `reg_w` out 1: register file write
- `mem_w` out 1: memory write
- `branch` out 1: PC loads from result bus
- `illegal` out 1: one-cycle pulse on op = 2'b11
- `state` out 4: current state encoding
- `instr_count` out 32: retired-instruction counter

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; codes 10-15 return to FETCH.
- Unlisted outputs are 0 in each state.
- FETCH: mem_req=1, adr_src=0, ir_write=1, pc_write=1, alu_src_a=1, alu_src_b=2, result_src=2; next DECODE.
- DECODE: alu_src_a=1, alu_src_b=2, result_src=2 (R15 = PC+8).
  - cond_ex=0 → FETCH.
  - op=01 → MEMADR.
  - op=00 → EXECI when funct[5]=1, else EXECR.
  - op=10 → BRANCH.
  - op=11 → FETCH with illegal=1.
- MEMADR: alu_src_a=0, alu_src_b=1, alu_op=0; next MEMRD when funct[0]=1, else MEMWR.
- MEMRD: mem_req=1, adr_src=1 → MEMWB. MEMWB: result_src=1, reg_w=1 → FETCH.
- MEMWR: mem_req=1, adr_src=1, mem_w=1 → FETCH.
- EXECR: alu_src_a=0, alu_src_b=0, alu_op=1 → ALUWB. EXECI: same, but alu_src_b=1.
- ALUWB: result_src=0, reg_w = ~no_write → FETCH.
- BRANCH: alu_src_a=0, alu_src_b=1, alu_op=0, result_src=2, branch=1 → FETCH.
- instr_count increments by 1 on every transition into FETCH from any state other than FETCH, including the cond-fail and illegal paths. It wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset (async, reset_n=0): state=FETCH and instr_count=0 immediately.
- While reset_n=0, every strobe is forced 0 combinationally: ir_write, pc_write, reg_w, mem_w, mem_req, branch, illegal. Selects show FETCH values.
- First fetch strobe: in the first cycle after reset_n deasserts.
- Reset asserted mid-instruction aborts it; no partial writeback occurs after reset.
- Cycles per instruction without wait states:
  - data-processing: 4
  - load: 5
  - store: 4
  - branch: 3
  - cond-fail or illegal: 2
- All outputs are pure decodes of `state` (plus no_write/mem_ready where stated). There is no output register stage.

## Configuration
- `MULTICYCLE_MEM_WAIT_EN` defined: FETCH, MEMRD and MEMWR hold their state while mem_ready=0.
  - During the hold, mem_req stays 1.
  - ir_write, pc_write and mem_w assert only in the cycle where mem_ready=1.
  - The transition happens on that same edge.
  - instr_count does not change during the hold.
- Not defined: mem_ready is ignored (treated as 1); every memory state lasts exactly one cycle.

## Test plan
- Reset: hold reset_n=0 for 3 cycles → state=0, all strobes 0, instr_count=0. Release → ir_write=1 in the next cycle.
- ADD reg (op=00, funct=6'b001000, cond_ex=1) → states 0,1,6,8,0; reg_w=1 only in ALUWB; instr_count=1.
- LDR (op=01, funct[0]=1), then STR (funct[0]=0):
  - LDR → 0,1,2,3,4,0.
  - STR → 0,1,2,5,0 with mem_w=1 in state 5 only.
  - instr_count=2.
- CMP (no_write=1) → ALUWB with reg_w=0. Branch with cond_ex=0 → 0,1,0, branch never 1, instr_count still increments.
- op=11 → illegal pulses 1 cycle in DECODE, then FETCH. Preset instr_count to 0xFFFF_FFFF → wraps to 0.
- With MULTICYCLE_MEM_WAIT_EN, on LDR, hold mem_ready=0 for 3 cycles in MEMRD → state stays 3, mem_req=1. Then mem_ready=1 → MEMWB next cycle; total 8 cycles.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM sequencing the shared multicycle ARM datapath.
// Optional build macro MULTICYCLE_MEM_WAIT_EN lets FETCH/MEMRD/MEMWR stall on mem_ready.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic        cond_ex,
  input  logic        no_write,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        adr_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic        alu_op,
  output logic        reg_w,
  output logic        mem_w,
  output logic        branch,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic        ready;
  logic        mem_req_raw, ir_write_raw, pc_write_raw;
  logic        reg_w_raw, mem_w_raw, branch_raw, illegal_raw;
  logic [31:0] count_q;
  logic        unused_funct;

  assign unused_funct = ^funct[4:1];

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign ready = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign ready = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  // Retire on every entry into FETCH from elsewhere; a held FETCH does not count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count_q <= 32'd0;
    else if ((state_q != FETCH) && (state_d == FETCH))
      count_q <= count_q + 32'd1;
  end

  always_comb begin
    state_d      = state_q;
    mem_req_raw  = 1'b0;
    ir_write_raw = 1'b0;
    pc_write_raw = 1'b0;
    reg_w_raw    = 1'b0;
    mem_w_raw    = 1'b0;
    branch_raw   = 1'b0;
    illegal_raw  = 1'b0;
    adr_src      = 1'b0;
    alu_src_a    = 2'd0;
    alu_src_b    = 2'd0;
    result_src   = 2'd0;
    alu_op       = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req_raw  = 1'b1;
        ir_write_raw = ready;
        pc_write_raw = ready;
        alu_src_a    = 2'd1;
        alu_src_b    = 2'd2;
        result_src   = 2'd2;
        if (ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        if (!cond_ex) begin
          state_d = FETCH;
        end else begin
          case (op)
            2'b00:   state_d = funct[5] ? EXECI : EXECR;
            2'b01:   state_d = MEMADR;
            2'b10:   state_d = BRANCH;
            default: begin
              state_d     = FETCH;
              illegal_raw = 1'b1;
            end
          endcase
        end
      end
      MEMADR: begin
        alu_src_b = 2'd1;
        state_d   = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req_raw = 1'b1;
        adr_src     = 1'b1;
        if (ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'd1;
        reg_w_raw  = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_req_raw = 1'b1;
        adr_src     = 1'b1;
        mem_w_raw   = ready;
        if (ready) state_d = FETCH;
      end
      EXECR: begin
        alu_op  = 1'b1;
        state_d = ALUWB;
      end
      EXECI: begin
        alu_src_b = 2'd1;
        alu_op    = 1'b1;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_w_raw = ~no_write;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_b  = 2'd1;
        result_src = 2'd2;
        branch_raw = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Strobes are masked directly by reset_n so nothing fires while reset is held.
  assign mem_req     = mem_req_raw  & reset_n;
  assign ir_write    = ir_write_raw & reset_n;
  assign pc_write    = pc_write_raw & reset_n;
  assign reg_w       = reg_w_raw    & reset_n;
  assign mem_w       = mem_w_raw    & reset_n;
  assign branch      = branch_raw   & reset_n;
  assign illegal     = illegal_raw  & reset_n;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule
